// File: rtl/laplace_stream_ctrl_if.sv
// Pixel-in / result-out stream bundle plus frame control for laplace_stream_ctrl.
// The slave modport is the controller side; master is the source/sink side.
interface laplace_stream_ctrl_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done
    );

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/laplace_stream_ctrl.sv
// Streaming 5-point Laplace controller: two line buffers, 3-column window, single-stage output register.
// Optional LAPLACE_BORDER_PASS_EN: border centres output the original pixel instead of 0.
module laplace_stream_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    laplace_stream_ctrl_if.slave  bus
);

    // IDLE wait start | FILL prime buffers | RUN one result per pixel | FLUSH drain last IMG_W+1 | DONE pulse done
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [COL_W-1:0] LP_COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LP_ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] LP_COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] LP_ROW_ONE  = ROW_W'(1);

    state_t             r_state;
    logic [ROW_W-1:0]   r_irow;
    logic [COL_W-1:0]   r_icol;
    logic [ROW_W-1:0]   r_orow;
    logic [COL_W-1:0]   r_ocol;
    logic               r_out_valid;
    logic [7:0]         r_out_data;
    logic               r_out_last;
    logic               r_busy;
    logic               r_done;

    logic [7:0]         r_lb0 [IMG_W];
    logic [7:0]         r_lb1 [IMG_W];
    logic [7:0]         r_w0_top;
    logic [7:0]         r_w0_mid;
    logic [7:0]         r_w0_bot;
    logic [7:0]         r_w1_mid;

    logic               w_slot;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_in_last;
    logic               w_prime_done;
    logic               w_produce;
    logic [7:0]         w_lb0_rd;
    logic [7:0]         w_lb1_rd;
    logic [9:0]         w_sum;
    logic [10:0]        w_t;
    logic [7:0]         w_kern;
    logic               w_border;
    logic [7:0]         w_border_val;
    logic [7:0]         w_res_data;
    logic               w_res_last;

    assign w_slot       = !r_out_valid || bus.out_ready;
    assign w_in_ready   = ((r_state == S_FILL) || (r_state == S_RUN)) && w_slot;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_in_last    = (r_irow == LP_ROW_LAST) && (r_icol == LP_COL_LAST);
    assign w_prime_done = (r_irow == LP_ROW_ONE) && (r_icol == LP_COL_ONE);
    assign w_produce    = ((r_state == S_RUN) && w_accept)
                       || ((r_state == S_FILL) && w_accept && w_prime_done)
                       || ((r_state == S_FLUSH) && w_slot && !(r_out_valid && r_out_last));

    assign w_lb0_rd = r_lb0[r_icol];
    assign w_lb1_rd = r_lb1[r_icol];

    // At acceptance of (R,C): window col C-1 gives b/e/h, col C-2 gives d, line buffer 1 gives f.
    assign w_sum  = 10'(r_w0_top) + 10'(r_w1_mid) + 10'(w_lb1_rd) + 10'(r_w0_bot);
    assign w_t    = {1'b0, w_sum} - {1'b0, r_w0_mid, 2'b00};
    assign w_kern = w_t[10] ? 8'h00 : ((|w_t[9:8]) ? 8'hFF : w_t[7:0]);

    assign w_border = (r_orow == '0) || (r_orow == LP_ROW_LAST)
                   || (r_ocol == '0) || (r_ocol == LP_COL_LAST);

`ifdef LAPLACE_BORDER_PASS_EN
    // After the last pixel, w0_mid still holds (IMG_H-2, IMG_W-1) and line buffer 1 holds the last row.
    logic [7:0] w_e_flush;
    assign w_e_flush    = (r_orow == ROW_W'(IMG_H - 2)) ? r_w0_mid : r_lb1[r_ocol];
    assign w_border_val = (r_state == S_FLUSH) ? w_e_flush : r_w0_mid;
`else
    assign w_border_val = 8'h00;
`endif

    assign w_res_data = w_border ? w_border_val : w_kern;
    assign w_res_last = (r_orow == LP_ROW_LAST) && (r_ocol == LP_COL_LAST);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[r_icol] <= w_lb1_rd;
            r_lb1[r_icol] <= bus.in_data;
            r_w1_mid      <= r_w0_mid;
            r_w0_top      <= w_lb0_rd;
            r_w0_mid      <= w_lb1_rd;
            r_w0_bot      <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_irow      <= '0;
            r_icol      <= '0;
            r_orow      <= '0;
            r_ocol      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_FILL;
                        r_busy  <= 1'b1;
                        r_irow  <= '0;
                        r_icol  <= '0;
                        r_orow  <= '0;
                        r_ocol  <= '0;
                    end
                end
                S_FILL, S_RUN: begin
                    if (w_accept) begin
                        if (r_icol == LP_COL_LAST) begin
                            r_icol <= '0;
                            if (r_irow != LP_ROW_LAST) r_irow <= r_irow + 1'b1;
                        end else begin
                            r_icol <= r_icol + 1'b1;
                        end
                        if ((r_state == S_FILL) && w_prime_done) r_state <= S_RUN;
                        if ((r_state == S_RUN) && w_in_last)     r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (r_out_valid && r_out_last && bus.out_ready) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_produce) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res_data;
                r_out_last  <= w_res_last;
                if (r_ocol == LP_COL_LAST) begin
                    r_ocol <= '0;
                    if (r_orow != LP_ROW_LAST) r_orow <= r_orow + 1'b1;
                end else begin
                    r_ocol <= r_ocol + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_laplace_stream_ctrl.sv
// Directed bench for laplace_stream_ctrl: a 4x4 and a 5x5 instance share one driver selected by r_sel.
module tb_laplace_stream_ctrl;

    logic       clk;
    logic       rst_n;
    logic       r_sel;
    logic       tb_start;
    logic       tb_in_valid;
    logic       tb_out_ready;
    logic [7:0] tb_in_data;

    int         errors;
    int         checks;
    logic [7:0] pix     [25];
    logic [7:0] got     [25];
    logic [7:0] ref_res [25];
    int         n_got;

    laplace_stream_ctrl_if bus4 ();
    laplace_stream_ctrl_if bus5 ();

    laplace_stream_ctrl #(.IMG_W(4), .IMG_H(4), .COL_W(2), .ROW_W(2)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    laplace_stream_ctrl #(.IMG_W(5), .IMG_H(5), .COL_W(3), .ROW_W(3)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    assign bus4.start     = tb_start && !r_sel;
    assign bus5.start     = tb_start && r_sel;
    assign bus4.in_valid  = tb_in_valid && !r_sel;
    assign bus5.in_valid  = tb_in_valid && r_sel;
    assign bus4.in_data   = tb_in_data;
    assign bus5.in_data   = tb_in_data;
    assign bus4.out_ready = tb_out_ready;
    assign bus5.out_ready = tb_out_ready;

    logic       w_in_ready, w_out_valid, w_out_last, w_busy, w_done;
    logic [7:0] w_out_data;
    assign w_in_ready  = r_sel ? bus5.in_ready  : bus4.in_ready;
    assign w_out_valid = r_sel ? bus5.out_valid : bus4.out_valid;
    assign w_out_data  = r_sel ? bus5.out_data  : bus4.out_data;
    assign w_out_last  = r_sel ? bus5.out_last  : bus4.out_last;
    assign w_busy      = r_sel ? bus5.busy      : bus4.busy;
    assign w_done      = r_sel ? bus5.done      : bus4.done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int exp_px(input int w, input int h, input int r, input int c);
        int e;
        int t;
        e = int'(pix[r*w+c]);
        if (r == 0 || r == h-1 || c == 0 || c == w-1) begin
`ifdef LAPLACE_BORDER_PASS_EN
            return e;
`else
            return 0;
`endif
        end
        t = int'(pix[(r-1)*w+c]) + int'(pix[r*w+c-1]) + int'(pix[r*w+c+1])
          + int'(pix[(r+1)*w+c]) - 4*e;
        if (t < 0)   return 0;
        if (t > 255) return 255;
        return t;
    endfunction

    task automatic check_model(input string tag, input int w, input int h);
        for (int i = 0; i < w*h; i++)
            check($sformatf("%s[%0d]", tag, i), got[i], exp_px(w, h, i / w, i % w));
    endtask

    task automatic run_frame(input int w, input int h, input int p_in, input int p_out,
                             input int abort_at, input bit start_mid);
        int         pi;
        int         lat_acc;
        int         lat_out;
        bit         fin;
        bit         hold_pend;
        logic [7:0] hold_val;
        pi = 0; lat_acc = -1; lat_out = -1; fin = 0; hold_pend = 0; hold_val = 0;
        n_got = 0;
        @(negedge clk);
        tb_start = 1'b1;
        @(negedge clk);
        tb_start = 1'b0;
        #1 check("busy_start", w_busy, 1);
        for (int k = 0; k < 3000 && !fin; k++) begin
            @(negedge clk);
            tb_start     = start_mid && (k == 8);
            tb_in_valid  = (pi < w*h) && ($urandom_range(99) < p_in);
            tb_in_data   = (pi < w*h) ? pix[pi] : 8'h00;
            tb_out_ready = ($urandom_range(99) < p_out);
            #1;
            if (hold_pend) begin
                check("hold_valid", w_out_valid, 1);
                check("hold_data", w_out_data, hold_val);
            end
            hold_pend = w_out_valid && !tb_out_ready;
            hold_val  = w_out_data;
            if (w_out_valid && lat_out < 0) lat_out = k;
            if (tb_in_valid && w_in_ready) begin
                if (pi == w + 1) lat_acc = k;
                pi++;
            end
            if (w_out_valid && tb_out_ready) begin
                got[n_got] = w_out_data;
                check("last", w_out_last, (n_got == w*h - 1) ? 1 : 0);
                n_got++;
                if (n_got == w*h) fin = 1;
            end
            if (abort_at >= 0 && pi >= abort_at) fin = 1;
        end
        if (!fin) check("timeout", 0, 1);
        if (abort_at < 0) begin
            if (p_in == 100 && p_out == 100) check("latency", lat_out - lat_acc, 1);
            check("count", n_got, w*h);
            @(negedge clk);
            tb_in_valid = 1'b0;
            #1;
            check("done", w_done, 1);
            check("busy_end", w_busy, 0);
            @(negedge clk);
            #1 check("done_pulse", w_done, 0);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; r_sel = 1'b0;
        tb_start = 1'b0; tb_in_valid = 1'b0; tb_out_ready = 1'b0; tb_in_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            r_sel = s[0];
            #1;
            check("rst_in_ready", w_in_ready, 0);
            check("rst_out_valid", w_out_valid, 0);
            check("rst_out_data", w_out_data, 0);
            check("rst_busy", w_busy, 0);
            check("rst_done", w_done, 0);
        end

        // 4x4 flat frame
        r_sel = 1'b0;
        for (int i = 0; i < 16; i++) pix[i] = 8'd10;
        run_frame(4, 4, 100, 100, -1, 0);
        check_model("flat", 4, 4);
`ifndef LAPLACE_BORDER_PASS_EN
        check("flat_c11", got[5], 0);
`endif

        // 5x5 impulse of 50 at centre
        r_sel = 1'b1;
        for (int i = 0; i < 25; i++) pix[i] = 8'd0;
        pix[12] = 8'd50;
        run_frame(5, 5, 100, 100, -1, 0);
        check_model("imp", 5, 5);
        check("imp_12", got[7], 50);
        check("imp_21", got[11], 50);
        check("imp_23", got[13], 50);
        check("imp_32", got[17], 50);
        check("imp_22", got[12], 0);

        // 5x5 all 255 with a hole at centre
        for (int i = 0; i < 25; i++) pix[i] = 8'd255;
        pix[12] = 8'd0;
        run_frame(5, 5, 100, 100, -1, 0);
        check_model("hole", 5, 5);
        check("hole_22", got[12], 255);
        check("hole_12", got[7], 0);
        check("hole_32", got[17], 0);

        // 5x5 quadratic ramp: interior Laplacian is 2*9 + 2*5 = 28
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                pix[r*5+c] = 8'(r*r*9 + c*c*5 + 1);
        run_frame(5, 5, 100, 100, -1, 0);
        check_model("ramp", 5, 5);
        check("ramp_22", got[12], 28);
        for (int i = 0; i < 25; i++) ref_res[i] = got[i];
        run_frame(5, 5, 50, 30, -1, 0);
        for (int i = 0; i < 25; i++) check($sformatf("stall[%0d]", i), got[i], ref_res[i]);

        // Reset in the middle of a 4x4 frame, right after result (1,1)=255 is loaded
        r_sel = 1'b0;
        for (int i = 0; i < 16; i++) pix[i] = 8'd200;
        pix[5] = 8'd0;
        run_frame(4, 4, 100, 100, 12, 0);
        check("pre_rst_data", w_out_data, 255);
        #2 rst_n = 1'b0;
        tb_in_valid = 1'b0;
        #1;
        check("mid_rst_in_ready", w_in_ready, 0);
        check("mid_rst_out_valid", w_out_valid, 0);
        check("mid_rst_out_data", w_out_data, 0);
        check("mid_rst_out_last", w_out_last, 0);
        check("mid_rst_busy", w_busy, 0);
        check("mid_rst_done", w_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh 4x4 frame pixel=row*4+col with a stray start while busy
        for (int i = 0; i < 16; i++) pix[i] = 8'(i);
        run_frame(4, 4, 100, 100, -1, 1);
        check_model("after_rst", 4, 4);
        check("c11", got[5], 0);
`ifdef LAPLACE_BORDER_PASS_EN
        check("pass_c33", got[15], 15);
        check("pass_c03", got[3], 3);
        check("pass_c30", got[12], 12);
`else
        check("zero_c33", got[15], 0);
        check("zero_c03", got[3], 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
